// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx receiver.
//  - UART_CLKS_PER_BIT : default bit period in clk cycles (125 MHz / 115200)
//  - rx_state_e        : receiver FSM state codes
//  - cnt_width()       : width of the bit-period counter for a given bit period
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 1085;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Counter must hold 0..clks-1; never narrower than one bit.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  synchronous, active-high; both flops load RST_VAL
//   d    in  1  asynchronous input
//   q    out 1  synchronized output (2 cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      // stage boundary: p0 may be metastable, p1 is the clean copy
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a one-entry output buffer and a
// valid/ready handshake.
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial line, idles high
//   rx_data    out  8  received byte, meaningful while rx_valid=1
//   rx_valid   out  1  buffer holds an unconsumed byte
//   rx_ready   in   1  consumer takes the byte on an edge with rx_valid & rx_ready
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  one-cycle pulse: a byte landed while the buffer was still full
//   busy       out  1  FSM not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s;
  rx_state_e       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            byte_done, byte_done_n;
  logic            frame_err_n;

  // Reset value 1 keeps the line looking idle so reset cannot fake a start bit.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // ---- FSM state and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      byte_done <= byte_done_n;
      frame_err <= frame_err_n;
    end
  end

  // Shift register is pure data: its content only matters once a full frame
  // has been shifted in, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    byte_done_n = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = ST_START;
      end

      // Re-check the line at mid start bit; from here on every sample
      // is one full bit period later, i.e. at mid bit.
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end
      end

      // Leaving at mid stop bit lets a back-to-back start bit be seen.
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_done_n = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_BREAK;
          end
        end
      end

      // A line stuck low must go high before another frame may start.
      ST_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end

      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // ---- output buffer ----
  // A new byte always wins: with rx_ready=1 the old byte counts as consumed,
  // with rx_ready=0 it is lost and overrun flags it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
